// File: rtl/clm_mul_arbiter_if.sv
// clm_mul_arbiter_if: requester, PRNG and multiplier signals of the shared CLM multiplier arbiter
interface clm_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W = 8,
  parameter int PDW = 2,
  parameter int RPW = 9,
  parameter int D = 1,
  parameter int IW = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req_valid, req_ready;
  logic [N_REQ-1:0][W-1:0] req_p1, req_p2;
  logic [N_REQ-1:0][PDW-1:0] req_p_det;
  logic rsp_valid, rsp_err;
  logic [IW-1:0] rsp_id;
  logic [W-1:0] rsp_out;
  logic rnd_valid, rnd_ready;
  logic [0:8+D][RPW-1:0] rnd_data;
  logic mul_drdy_i, mul_drdy_o, mul_rst, busy;
  logic [W-1:0] mul_p1, mul_p2, mul_out;
  logic [PDW-1:0] mul_p_det;
  logic [0:8+D][RPW-1:0] mul_random_vect;
  modport slave (
    input req_valid, req_p1, req_p2, req_p_det, rnd_valid, rnd_data, mul_drdy_o, mul_out,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_err, rnd_ready, mul_drdy_i,
           mul_p1, mul_p2, mul_p_det, mul_random_vect, mul_rst, busy
  );
  modport master (
    output req_valid, req_p1, req_p2, req_p_det, rnd_valid, rnd_data, mul_drdy_o, mul_out,
    input req_ready, rsp_valid, rsp_id, rsp_out, rsp_err, rnd_ready, mul_drdy_i,
          mul_p1, mul_p2, mul_p_det, mul_random_vect, mul_rst, busy
  );
endinterface

// File: rtl/clm_mul_arbiter.sv
// clm_mul_arbiter: round-robin sequencer sharing one masked CLM multiplier (WAIT timeout abort under CLM_ARB_TIMEOUT_EN)
module clm_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int W = 8,
  parameter int PDW = 2,
  parameter int RPW = 9,
  parameter int D = 1
) (
  input logic clk,
  input logic rst,
  clm_mul_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [2:0] IDLE = 3'd0, RAND = 3'd1, ISSUE = 3'd2, WAIT = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [IW-1:0] prio, g, gnt, nxt;
  logic [W-1:0] p1_q, p2_q, prod_q;
  logic [PDW-1:0] pd_q;
  logic [0:8+D][RPW-1:0] rv_q;
  logic err_q, any, fire, live, abort;
  always_comb begin
    gnt = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      for (int j = 0; j < N_REQ; j++)
        if (bus.req_valid[j] && (int'(prio) + i) % N_REQ == j) gnt = IW'(j);
  end
  assign nxt = (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
  assign any = |bus.req_valid;
  assign live = !rst;
  assign fire = live && state == IDLE && any;
`ifdef CLM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || state != WAIT) ? '0 : cnt + 1'b1;
  assign abort = live && state == WAIT && !bus.mul_drdy_o && cnt == CW'(TIMEOUT - 1);
`else
  assign abort = TIMEOUT < 0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= '0;
      g <= '0;
      p1_q <= '0;
      p2_q <= '0;
      pd_q <= '0;
      rv_q <= '0;
      prod_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state <= RAND;
          g <= gnt;
          prio <= nxt;
          p1_q <= bus.req_p1[gnt];
          p2_q <= bus.req_p2[gnt];
          pd_q <= bus.req_p_det[gnt];
          err_q <= 1'b0;
        end
        RAND: if (bus.rnd_valid) begin
          rv_q <= bus.rnd_data;
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (bus.mul_drdy_o) begin
          prod_q <= bus.mul_out;
          state <= DONE;
        end else if (abort) begin
          prod_q <= '0;
          err_q <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = fire ? N_REQ'(1) << gnt : '0;
  assign bus.rnd_ready = live && state == RAND;
  assign bus.mul_drdy_i = live && state == ISSUE;
  assign bus.rsp_valid = live && state == DONE;
  assign bus.rsp_err = bus.rsp_valid && err_q;
  assign bus.rsp_id = g;
  assign bus.rsp_out = prod_q;
  assign bus.busy = live && state != IDLE;
  assign bus.mul_rst = rst || abort;
  assign bus.mul_p1 = p1_q;
  assign bus.mul_p2 = p2_q;
  assign bus.mul_p_det = pd_q;
  assign bus.mul_random_vect = rv_q;
endmodule

// File: tb/tb_clm_mul_arbiter.sv
// tb_clm_mul_arbiter: randomized scenario bench for clm_mul_arbiter with a grant/latency reference model
module tb_clm_mul_arbiter;
  localparam int N = 4, W = 8, PDW = 2, RPW = 9, D = 1, TMO = 16, NV = 9 + D;
  typedef logic [0:NV-1][RPW-1:0] vec_t;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0, n_fail = 0, cyc = 0, m_prio = 0, vseq = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  clm_mul_arbiter_if #(.N_REQ(N), .W(W), .PDW(PDW), .RPW(RPW), .D(D)) bus ();
  clm_mul_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .W(W), .PDW(PDW), .RPW(RPW), .D(D)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  function automatic vec_t new_vec();
    vec_t v;
    for (int i = 0; i < NV; i++) v[i] = RPW'($urandom);
    vseq++;
    v[0] = RPW'(vseq);
    return v;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_p1[i] = W'($urandom);
      bus.req_p2[i] = W'($urandom);
      bus.req_p_det[i] = PDW'($urandom);
    end
  endtask

  // One operation from the IDLE cycle T (current negedge) to the following IDLE cycle; L = 0 means the multiplier never answers.
  task automatic op(input logic [N-1:0] vm, input int L, input int stall, input bit spur,
                    output int gid, output int tg, output vec_t vout);
    int g, k, lat;
    bit ab;
    logic [W-1:0] e1, e2, eo;
    logic [PDW-1:0] ep;
    vec_t ev;
    g = -1;
    eo = '0;
    ev = '0;
    for (int i = N - 1; i >= 0; i--) if (vm[(m_prio + i) % N]) g = (m_prio + i) % N;
    gid = g;
    tg = cyc;
    bus.req_valid = vm; bus.rnd_valid = (stall == 0); bus.rnd_data = new_vec(); bus.mul_drdy_o = spur;
    #1;
    n_tests++; if (bus.req_ready !== (4'(1) << g)) begin n_fail++; $display("FAIL grant req_ready got=%b exp=%b", bus.req_ready, 4'(1) << g); end
    n_tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rnd_ready !== 1'b0) begin n_fail++; $display("FAIL idle_outputs busy=%b rsp_valid=%b rnd_ready=%b exp=000", bus.busy, bus.rsp_valid, bus.rnd_ready); end
    e1 = bus.req_p1[g]; e2 = bus.req_p2[g]; ep = bus.req_p_det[g];
    m_prio = (g + 1) % N;
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      bus.rnd_valid = (s == stall); bus.rnd_data = new_vec(); bus.mul_drdy_o = spur && s < stall;
      #1;
      n_tests++; if (bus.rnd_ready !== 1'b1 || bus.mul_drdy_i !== 1'b0 || bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_phase rnd_ready=%b drdy_i=%b req_ready=%b rsp_valid=%b exp=1,0,0,0", bus.rnd_ready, bus.mul_drdy_i, bus.req_ready, bus.rsp_valid); end
      if (s == stall) ev = bus.rnd_data;
    end
    @(negedge clk);
    bus.rnd_valid = 1'($urandom); bus.rnd_data = new_vec(); bus.mul_drdy_o = 1'b0;
    #1;
    n_tests++; if (bus.mul_drdy_i !== 1'b1 || cyc - tg != 2 + stall) begin n_fail++; $display("FAIL issue drdy_i=%b at T+%0d exp=1 at T+%0d", bus.mul_drdy_i, cyc - tg, 2 + stall); end
    n_tests++; if (bus.mul_p1 !== e1 || bus.mul_p2 !== e2 || bus.mul_p_det !== ep) begin n_fail++; $display("FAIL operands got=%h,%h,%h exp=%h,%h,%h", bus.mul_p1, bus.mul_p2, bus.mul_p_det, e1, e2, ep); end
    n_tests++; if (bus.mul_random_vect !== ev || bus.rnd_ready !== 1'b0) begin n_fail++; $display("FAIL rand_vect got=%h exp=%h rnd_ready=%b", bus.mul_random_vect, ev, bus.rnd_ready); end
    ab = 1'b0;
    for (k = 1; k <= 1000; k++) begin
      @(negedge clk);
      bus.mul_drdy_o = (k == L); bus.mul_out = W'($urandom); bus.rnd_valid = 1'($urandom);
      #1;
      ab = (L == 0 && k == TMO);
      n_tests++; if (bus.mul_rst !== ab || bus.rsp_valid !== 1'b0 || bus.mul_drdy_i !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL wait k=%0d mul_rst=%b rsp_valid=%b drdy_i=%b busy=%b exp=%b,0,0,1", k, bus.mul_rst, bus.rsp_valid, bus.mul_drdy_i, bus.busy, ab); end
      n_tests++; if (bus.mul_p1 !== e1 || bus.mul_p2 !== e2 || bus.mul_random_vect !== ev) begin n_fail++; $display("FAIL wait_stable k=%0d p1=%h p2=%h exp=%h,%h", k, bus.mul_p1, bus.mul_p2, e1, e2); end
      if (k == L) eo = bus.mul_out;
      if (k == L || ab) break;
    end
    n_tests++; if (k > 1000) begin n_fail++; $display("FAIL wait_bound no exit within 1000 cycles exp=exit"); end
    lat = (L == 0) ? TMO : L;
    @(negedge clk);
    bus.mul_drdy_o = 1'b0;
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b1 || cyc - tg != 3 + stall + lat) begin n_fail++; $display("FAIL rsp_timing rsp_valid=%b at T+%0d exp=1 at T+%0d", bus.rsp_valid, cyc - tg, 3 + stall + lat); end
    n_tests++; if (bus.rsp_id !== 2'(g) || bus.rsp_out !== eo) begin n_fail++; $display("FAIL rsp_data id=%0d out=%h exp=%0d,%h", bus.rsp_id, bus.rsp_out, g, eo); end
    n_tests++; if (bus.rsp_err !== (L == 0) || bus.req_ready !== '0 || bus.mul_rst !== 1'b0) begin n_fail++; $display("FAIL rsp_flags err=%b req_ready=%b mul_rst=%b exp=%b,0,0", bus.rsp_err, bus.req_ready, bus.mul_rst, L == 0); end
    @(negedge clk);
    bus.req_valid = '0;
    vout = ev;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.req_valid = '1; bus.mul_drdy_o = 1'b1; bus.rnd_valid = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if (bus.mul_rst !== 1'b1 || bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rnd_ready !== 1'b0 || bus.mul_drdy_i !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_held mul_rst=%b req_ready=%b rsp_valid=%b rnd_ready=%b drdy_i=%b busy=%b", bus.mul_rst, bus.req_ready, bus.rsp_valid, bus.rnd_ready, bus.mul_drdy_i, bus.busy); end
    @(negedge clk);
    rst = 1'b0; bus.req_valid = '0; bus.mul_drdy_o = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.mul_rst !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_out !== '0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp busy=%b mul_rst=%b id=%0d out=%h err=%b exp=0", bus.busy, bus.mul_rst, bus.rsp_id, bus.rsp_out, bus.rsp_err); end
    n_tests++; if (bus.mul_p1 !== '0 || bus.mul_p2 !== '0 || bus.mul_p_det !== '0 || bus.mul_random_vect !== '0) begin n_fail++; $display("FAIL reset_mul p1=%h p2=%h pd=%h rv=%h exp=0", bus.mul_p1, bus.mul_p2, bus.mul_p_det, bus.mul_random_vect); end
    m_prio = 0;
  endtask

  task automatic test_single();
    int g, t;
    vec_t v;
    rand_ops();
    bus.req_p1[2] = 8'h53; bus.req_p2[2] = 8'hCA;
    op(4'b0100, 5, 0, 1'b0, g, t, v);
  endtask

  task automatic test_round_robin();
    int g, t, tp;
    vec_t v;
    tp = 0;
    rand_ops();
    for (int i = 0; i < 5; i++) begin
      op(4'b1111, 3, 0, 1'b0, g, t, v);
      if (i > 0) begin
        n_tests++; if (t - tp != 7) begin n_fail++; $display("FAIL rr_spacing got=%0d exp=7", t - tp); end
      end
      tp = t;
    end
  endtask

  task automatic test_starvation();
    int g, t;
    vec_t v1, v2;
    rand_ops();
    op(4'b1000, 3, 7, 1'b0, g, t, v1);
    op(4'b0010, 2, 7, 1'b0, g, t, v2);
    n_tests++; if (v1 === v2) begin n_fail++; $display("FAIL distinct_vectors got=%h exp=different", v2); end
  endtask

  task automatic test_spurious();
    int g, t;
    vec_t v;
    bus.req_valid = '0; bus.mul_drdy_o = 1'b1; bus.mul_out = 8'hA5;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL spur_idle busy=%b rsp_valid=%b exp=0,0", bus.busy, bus.rsp_valid); end
    @(negedge clk);
    bus.mul_drdy_o = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL spur_idle_next busy=%b rsp_valid=%b exp=0,0", bus.busy, bus.rsp_valid); end
    @(negedge clk);
    rand_ops();
    op(4'b0100, 2, 3, 1'b1, g, t, v);
  endtask

  task automatic test_reset_in_wait();
    int g, t;
    vec_t v;
    rand_ops();
    bus.req_valid = 4'b0001; bus.rnd_valid = 1'b1; bus.rnd_data = new_vec(); bus.mul_drdy_o = 1'b0;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rw_grant got=%b exp=0001", bus.req_ready); end
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (bus.mul_rst !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_abort mul_rst=%b rsp_valid=%b exp=1,0", bus.mul_rst, bus.rsp_valid); end
    @(negedge clk);
    rst = 1'b0; bus.req_valid = '0; bus.mul_drdy_o = 1'b1;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rnd_ready !== 1'b0 || bus.mul_drdy_i !== 1'b0 || bus.req_ready !== '0 || bus.mul_rst !== 1'b0) begin n_fail++; $display("FAIL rw_ctrl busy=%b rsp_valid=%b rnd_ready=%b drdy_i=%b req_ready=%b mul_rst=%b exp=0", bus.busy, bus.rsp_valid, bus.rnd_ready, bus.mul_drdy_i, bus.req_ready, bus.mul_rst); end
    n_tests++; if (bus.mul_p1 !== '0 || bus.mul_p2 !== '0 || bus.mul_p_det !== '0 || bus.mul_random_vect !== '0 || bus.rsp_id !== '0 || bus.rsp_out !== '0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rw_data p1=%h p2=%h rv=%h id=%0d out=%h exp=0", bus.mul_p1, bus.mul_p2, bus.mul_random_vect, bus.rsp_id, bus.rsp_out); end
    @(negedge clk);
    bus.mul_drdy_o = 1'b0;
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rw_quiet rsp_valid=%b busy=%b exp=0,0", bus.rsp_valid, bus.busy); end
    m_prio = 0;
    @(negedge clk);
    rand_ops();
    op(4'b1111, 4, 1, 1'b0, g, t, v);
  endtask

  task automatic test_timeout();
    int g, t;
    vec_t v;
    rand_ops();
`ifdef CLM_ARB_TIMEOUT_EN
    op(4'b0010, 0, 0, 1'b0, g, t, v);
    op(4'b0010, TMO, 0, 1'b0, g, t, v);
`else
    op(4'b0010, 40, 0, 1'b0, g, t, v);
`endif
  endtask

  task automatic test_random();
    int g, t;
    vec_t v;
    logic [N-1:0] m;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      m = N'($urandom_range(1, (1 << N) - 1));
      op(m, $urandom_range(1, 6), $urandom_range(0, 2), 1'($urandom), g, t, v);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_p1 = '0; bus.req_p2 = '0; bus.req_p_det = '0;
    bus.rnd_valid = 1'b0; bus.rnd_data = '0; bus.mul_drdy_o = 1'b0; bus.mul_out = '0;
    test_reset();
    test_single();
    test_reset();
    test_round_robin();
    test_starvation();
    test_spurious();
    test_reset_in_wait();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
